// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: state encoding,
// operand/tag widths, request payload layout and divider constants.
package div_issue_ctrl_pkg;

  localparam int unsigned MANT_W          = 24;
  localparam int unsigned TAG_W           = 4;
  localparam int unsigned REQ_W           = 2 * MANT_W + TAG_W;
  localparam int unsigned DIV_LATENCY_DEF = 17;

  // Quotient reported when the divisor is not normalized.
  localparam logic [MANT_W-1:0] DIV_ERR_Q = 24'hFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } div_req_t;

  // A divisor is usable only when its hidden one is set.
  function automatic logic divisor_ok(input logic [MANT_W-1:0] b);
    return b[MANT_W-1];
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider issue controller; DEPTH entries of W bits,
// first-word-fall-through head, simultaneous push/pop allowed when full.
module div_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 52
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues queued mantissa divisions to a fixed-latency divider one at a time
// and returns each quotient, or an error result for unnormalized divisors.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [MANT_W-1:0] req_a,
  input  logic [MANT_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              div_start,
  output logic [MANT_W-1:0] div_a,
  output logic [MANT_W-1:0] div_b,
  input  logic              div_busy,
  input  logic              div_stall,
  input  logic [MANT_W-1:0] div_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [MANT_W-1:0] rsp_q,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

  div_state_e        state_q;
  div_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  div_req_t          push_req;
  div_req_t          head;
  logic [REQ_W-1:0]  push_bits;
  logic [REQ_W-1:0]  head_bits;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              div_start_d;
  logic [MANT_W-1:0] div_a_d;
  logic [MANT_W-1:0] div_b_d;
  logic              rsp_valid_d;
  logic [MANT_W-1:0] rsp_q_d;
  logic [TAG_W-1:0]  rsp_tag_d;
  logic              rsp_err_d;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign push_req  = '{a: req_a, b: req_b, tag: req_tag};
  assign push_bits = push_req;
  assign head      = div_req_t'(head_bits);

  div_req_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_bits),
    .pop       (pop),
    .head_data (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and next-output logic; the head is popped when its response is produced.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    div_start_d = 1'b0;
    div_a_d     = div_a;
    div_b_d     = div_b;
    rsp_valid_d = rsp_valid;
    rsp_q_d     = rsp_q;
    rsp_tag_d   = rsp_tag;
    rsp_err_d   = rsp_err;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (!divisor_ok(head.b)) begin
            state_d     = ST_HOLD;
            pop         = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_q_d     = DIV_ERR_Q;
            rsp_tag_d   = head.tag;
            rsp_err_d   = 1'b1;
          end else if (!div_busy && !div_stall) begin
            state_d     = ST_ISSUE;
            div_start_d = 1'b1;
            div_a_d     = head.a;
            div_b_d     = head.b;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(DIV_LATENCY)) begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_q_d     = div_q;
          rsp_tag_d   = head.tag;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_start <= div_start_d;
      div_a     <= div_a_d;
      div_b     <= div_b_d;
      rsp_valid <= rsp_valid_d;
      rsp_q     <= rsp_q_d;
      rsp_tag   <= rsp_tag_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries (power of 2).
REQ-002 SHALL have parameter DIV_LATENCY, default 17, clocks from the div_start edge to the first cycle div_q is valid.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  in  1  upstream request present.
REQ-006 SHALL have port req_ready  out  1  FIFO can accept a request.
REQ-007 SHALL have ports req_a, req_b  in  24 each  normalized mantissas, with bit 23 as the hidden one.
REQ-008 SHALL have port req_tag  in  4  opaque request ID, returned with the result.
REQ-009 SHALL have port div_start  out  1  one-cycle start pulse to the divider.
REQ-010 SHALL have ports div_a, div_b  out  24 each  operands to the divider.
REQ-011 SHALL have ports div_busy, div_stall  in  1 each  divider status.
REQ-012 SHALL have port div_q  in  24  divider quotient.
REQ-013 SHALL have port rsp_valid  out  1  result present.
REQ-014 SHALL have port rsp_ready  in  1  downstream accepts the result.
REQ-015 SHALL have ports rsp_q (24), rsp_tag (4), rsp_err (1)  out  quotient, ID and divide-by-unnormalized flag.

Function
REQ-016 SHALL push {a,b,tag} into the FIFO when req_valid & req_ready; req_ready = !full.
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and HOLD.
REQ-018 IDLE: SHALL go to ISSUE when the FIFO is non-empty, head b[23]=1, !div_busy and !div_stall.
REQ-019 IDLE: SHALL go directly to HOLD when the FIFO is non-empty and head b[23]=0, with rsp_q=24'hFFFFFF and rsp_err=1, without driving div_start.
REQ-020 ISSUE: SHALL assert div_start for exactly 1 cycle, load the latency counter with 1, and go to WAIT.
REQ-021 SHALL hold div_a/div_b equal to the FIFO head from the ISSUE cycle until leaving WAIT, since the divider samples operands one cycle after start.
REQ-022 WAIT: SHALL increment the counter each cycle, and at counter==DIV_LATENCY register div_q into rsp_q, set rsp_err=0, pop the FIFO, and go to HOLD.
REQ-023 HOLD: SHALL keep rsp_valid=1 with rsp_q/rsp_tag/rsp_err stable until rsp_ready, then go to IDLE on the same edge.
REQ-024 SHALL leave the FIFO unmodified while a response stalls in HOLD; pushes continue until the FIFO is full.
REQ-025 SHALL allow a push and a pop on the same edge when the FIFO is full, keeping count unchanged.
REQ-026 SHALL wrap FIFO pointers modulo DEPTH, with no overflow or underflow under legal handshakes.
REQ-027 SHALL ignore div_busy and div_stall outside IDLE.
REQ-028 SHALL have at most one division outstanding.
REQ-029 SHALL give a minimum request-to-response latency of 2 + DIV_LATENCY cycles (push, IDLE, ISSUE, WAIT).

Reset
REQ-030 SHALL on rst force FSM=IDLE, FIFO empty, counter=0, div_start=0, rsp_valid=0, rsp_q=0, rsp_tag=0, rsp_err=0, div_a=div_b=0, and req_ready=1 after release.
REQ-031 SHALL on rst mid-WAIT discard the in-flight division and never present its late div_q as a response.

Structure
REQ-032 SHALL place the state encoding, DIV_LATENCY default and DIV_ERR_Q=24'hFFFFFF in the shared divider package.
REQ-033 SHALL implement the FIFO as sub-module div_req_fifo (parameterized DEPTH, 52-bit entries).

Verification
REQ-034 SHALL check: single request a=24'h900000, b=24'hC00000, tag=3, with a stub divider returning 24'hABCDEF at cycle 17 -> rsp_q=24'hABCDEF, rsp_tag=3, rsp_err=0, rsp_valid 19 cycles after the push edge.
REQ-035 SHALL check: b=24'h400000 -> no div_start, rsp_q=24'hFFFFFF, rsp_err=1, next request still issued normally.
REQ-036 SHALL check: 5 back-to-back pushes with DEPTH=4 and rsp_ready=0 -> req_ready=0 after the 4th accepted, 5th held, rsp stable.
REQ-037 SHALL check: div_busy=1 held for 10 cycles while the FIFO is non-empty -> div_start stays 0, then issues the cycle after busy falls.
REQ-038 SHALL check: rst pulsed at WAIT counter=8 -> all outputs at reset values, no response for that tag.
REQ-039 SHALL check: 8 requests with random rsp_ready -> responses in order, tags 0..7, div_a/div_b stable throughout each ISSUE/WAIT.
